// File: rtl/muldiv_pkg.sv
// Purpose: shared op-codes, FSM states and helpers for the RV32M multiply/divide unit.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package muldiv_pkg;

   localparam int MD_XLEN = 32;

   // Funct7 value that marks an R-type instruction as an M-extension op
   localparam logic [6:0] MD_FUNCT7 = 7'b0000001;

   typedef enum logic [2:0] {
      MD_MUL    = 3'b000,
      MD_MULH   = 3'b001,
      MD_MULHSU = 3'b010,
      MD_MULHU  = 3'b011,
      MD_DIV    = 3'b100,
      MD_DIVU   = 3'b101,
      MD_REM    = 3'b110,
      MD_REMU   = 3'b111
   } md_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_FIX  = 2'd2,
      MD_DONE = 2'd3
   } md_state_e;

   // Two's-complement negate
   function automatic logic [MD_XLEN-1:0] neg(input logic [MD_XLEN-1:0] v);
      return ~v + 1'b1;
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Purpose: iterative RV32M mul/div (radix-2 shift-add, restoring divide) sharing one 2*WIDTH accumulator.
// Latency: done WIDTH+2 cycles after an accepted start; 1 cycle for divide-by-zero / signed overflow.
// Backpressure: busy is high in CALC/FIX and stalls the pipeline; start while busy is ignored.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MD_XLEN
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             flush,
   input  logic [2:0]       Funct3,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Result
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] W_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   md_state_e          r_state;
   md_state_e          w_state_nxt;
   logic [2:0]         r_op;
   logic [CNT_W-1:0]   r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_m;        // multiplicand (mul) or divisor (div) magnitude
   logic               r_neg;      // final result must be negated
   logic [WIDTH-1:0]   r_result;

   logic               w_accept;
   logic               w_sa, w_sb, w_neg_in;
   logic [WIDTH-1:0]   w_neg_a, w_neg_b, w_mag_a, w_mag_b;
   logic               w_special;
   logic [WIDTH-1:0]   w_special_res;

   logic [WIDTH:0]     w_mul_sum;
   logic [2*WIDTH-1:0] w_mul_step;
   logic [WIDTH:0]     w_rem_sh;
   logic [WIDTH:0]     w_diff;
   logic [2*WIDTH-1:0] w_div_step;

   logic [WIDTH-1:0]   w_lo, w_hi, w_lo_neg, w_hi_neg, w_hi_neg_rem;
   logic [WIDTH-1:0]   w_fix_res;

   assign Result = r_result;

   // Operand sign flags, magnitudes and result sign for the incoming op
   always_comb begin
      w_sa     = 1'b0;
      w_sb     = 1'b0;
      w_neg_in = 1'b0;
      case (Funct3)
         MD_MUL, MD_MULH, MD_DIV: begin
            w_sa     = SrcA[WIDTH-1];
            w_sb     = SrcB[WIDTH-1];
            w_neg_in = w_sa ^ w_sb;
         end
         MD_MULHSU: begin
            w_sa     = SrcA[WIDTH-1];
            w_neg_in = w_sa;
         end
         MD_REM: begin
            w_sa     = SrcA[WIDTH-1];
            w_sb     = SrcB[WIDTH-1];
            w_neg_in = w_sa;
         end
         default: ;
      endcase
      w_neg_a = neg(SrcA);
      w_neg_b = neg(SrcB);
      // neg(0x80000000) is 0x80000000, which is the right unsigned magnitude
      w_mag_a = w_sa ? w_neg_a : SrcA;
      w_mag_b = w_sb ? w_neg_b : SrcB;
   end

   // Divide-by-zero and signed overflow resolve without iterating
   always_comb begin
      w_special = Funct3[2] && ((SrcB == '0) ||
                  (((Funct3 == MD_DIV) || (Funct3 == MD_REM)) && (SrcA == W_MIN) && (SrcB == '1)));
      if (SrcB == '0)
         w_special_res = Funct3[1] ? SrcA : '1;
      else
         w_special_res = Funct3[1] ? '0 : W_MIN;
   end

   // One radix-2 iteration of both datapaths over the shared accumulator
   always_comb begin
      // multiply: {hi,lo} with multiplier in lo; add on lo[0], shift right
      w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});
      w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};
      // divide: {rem,quo} with dividend in quo; shift left, trial-subtract divisor
      w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
      w_diff     = w_rem_sh - {1'b0, r_m};
      if (!w_diff[WIDTH])
         w_div_step = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      else
         w_div_step = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
   end

   // Sign correction and half/quotient/remainder selection used in FIX
   always_comb begin
      w_lo         = r_acc[WIDTH-1:0];
      w_hi         = r_acc[2*WIDTH-1:WIDTH];
      w_lo_neg     = neg(w_lo);
      // high half of the negated 2*WIDTH product: the carry out of ~lo+1 only reaches hi when lo is 0
      w_hi_neg     = ~w_hi + {{(WIDTH-1){1'b0}}, (w_lo == '0)};
      w_hi_neg_rem = neg(w_hi);
      w_fix_res    = w_lo;
      if (!r_op[2]) begin
         if (r_op == MD_MUL)
            w_fix_res = r_neg ? w_lo_neg : w_lo;
         else
            w_fix_res = r_neg ? w_hi_neg : w_hi;
      end else if (r_op[1]) begin
         w_fix_res = r_neg ? w_hi_neg_rem : w_hi;
      end else begin
         w_fix_res = r_neg ? w_lo_neg : w_lo;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset)
         r_state <= MD_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // FSM next state, accept strobe and status outputs; flush overrides everything
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         MD_IDLE, MD_DONE: begin
            done = (r_state == MD_DONE);
            if (start && !flush) begin
               w_accept    = 1'b1;
               w_state_nxt = w_special ? MD_DONE : MD_CALC;
            end else begin
               w_state_nxt = MD_IDLE;
            end
         end
         MD_CALC: begin
            busy = 1'b1;
            if (r_cnt == CNT_W'(WIDTH-1))
               w_state_nxt = MD_FIX;
         end
         MD_FIX: begin
            busy        = 1'b1;
            w_state_nxt = MD_DONE;
         end
         default: w_state_nxt = MD_IDLE;
      endcase
      if (flush)
         w_state_nxt = MD_IDLE;
   end

   // Operand latch, iteration and result write-back; a flush freezes everything
   always_ff @(posedge clk) begin
      if (reset) begin
         r_op     <= '0;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_m      <= '0;
         r_neg    <= 1'b0;
         r_result <= '0;
      end else if (!flush) begin
         if (w_accept) begin
            r_op  <= Funct3;
            r_neg <= w_neg_in;
            r_cnt <= '0;
            if (Funct3[2]) begin
               r_acc <= {{WIDTH{1'b0}}, w_mag_a};
               r_m   <= w_mag_b;
            end else begin
               r_acc <= {{WIDTH{1'b0}}, w_mag_b};
               r_m   <= w_mag_a;
            end
            if (w_special)
               r_result <= w_special_res;
         end else if (r_state == MD_CALC) begin
            r_acc <= r_op[2] ? w_div_step : w_mul_step;
            r_cnt <= r_cnt + 1'b1;
         end else if (r_state == MD_FIX) begin
            r_result <= w_fix_res;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Purpose: self-checking bench for muldiv_unit against a plain-arithmetic RV32M model.
// Latency: checks done at start+34 (normal) and start+1 (special cases).
// Backpressure: checks busy window, ignored start while busy, flush and reset aborts.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset, start, flush;
   logic [2:0]  Funct3;
   logic [31:0] SrcA, SrcB;
   logic        busy, done;
   logic [31:0] Result;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_last;

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [12];

   muldiv_unit #(.WIDTH(32)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .flush  (flush),
      .Funct3 (Funct3),
      .SrcA   (SrcA),
      .SrcB   (SrcB),
      .busy   (busy),
      .done   (done),
      .Result (Result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // RV32M semantics with 64-bit integer arithmetic
   function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      logic ovf;
      sa  = longint'(signed'(a));
      sb  = longint'(signed'(b));
      ua  = longint'({32'd0, a});
      ub  = longint'({32'd0, b});
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      p   = 64'd0;
      case (op)
         3'd0: begin p = sa * sb; return p[31:0];  end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return 32'h8000_0000;
            p = sa / sb; return p[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'd0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      return op[2] && ((b == 0) ||
             (((op == 3'd4) || (op == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
   endfunction

   // Called #1 after a rising edge; start is accepted on the next edge (cycle T+1 begins after it)
   task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      Funct3 = op;
      SrcA   = a;
      SrcB   = b;
      start  = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
   endtask

   // k counts cycles after the accepting edge; returns 0 latency if done never arrives
   task automatic wait_done(input int k0, output int lat, output int bcnt);
      int k;
      k    = k0;
      lat  = 0;
      bcnt = 0;
      while (k < 60) begin
         if (done) begin
            lat = k;
            break;
         end
         if (busy) bcnt++;
         @(posedge clk); #1;
         k++;
      end
   endtask

   task automatic run_check(input string tag, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
      int lat, bcnt;
      bit sp;
      sp = is_special(op, a, b);
      launch(op, a, b);
      wait_done(1, lat, bcnt);
      check({tag, " result"}, Result, exp);
      check({tag, " latency"}, 32'(lat), sp ? 32'd1 : 32'd34);
      check({tag, " busy cycles"}, 32'(bcnt), sp ? 32'd0 : 32'd33);
      exp_last = exp;
      @(posedge clk); #1;
      check({tag, " done pulse width"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      int lat, bcnt, ndone;
      logic [2:0]  op;
      logic [31:0] a, b, exp;

      vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
      vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vecs[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000};
      vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
      vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
      vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14};
      vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2};
      vecs[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF};
      vecs[9]  = '{3'd7, 32'd5,          32'd0,         32'd5};
      vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
      vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};

      reset = 1'b1; start = 1'b0; flush = 1'b0;
      Funct3 = 3'd0; SrcA = 32'd0; SrcB = 32'd0;
      exp_last = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy",   {31'd0, busy}, 32'd0);
      check("reset done",   {31'd0, done}, 32'd0);
      check("reset result", Result,        32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Directed cases
      for (int i = 0; i < 12; i++)
         run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

      // Flush beats a coincident start
      Funct3 = 3'd0; SrcA = 32'd3; SrcB = 32'd4;
      start = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      check("flush+start busy", {31'd0, busy}, 32'd0);
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) ndone++;
         @(posedge clk); #1;
      end
      check("flush+start no done", 32'(ndone), 32'd0);

      // Flush in the middle of CALC
      launch(3'd0, 32'd1234, 32'd5678);
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush busy",   {31'd0, busy}, 32'd0);
      check("flush done",   {31'd0, done}, 32'd0);
      check("flush result", Result,        exp_last);
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) ndone++;
         @(posedge clk); #1;
      end
      check("flush no done",     32'(ndone), 32'd0);
      check("flush result held", Result,     exp_last);

      // Start pulsed while busy is ignored
      launch(3'd5, 32'd100, 32'd7);
      repeat (4) @(posedge clk);
      #1;
      Funct3 = 3'd0; SrcA = 32'd9; SrcB = 32'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(6, lat, bcnt);
      check("ignored start result",  Result,     32'd14);
      check("ignored start latency", 32'(lat),   32'd34);
      exp_last = 32'd14;
      @(posedge clk); #1;

      // Reset mid-operation
      launch(3'd3, 32'hDEAD_BEEF, 32'h1234_5678);
      repeat (19) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("midreset busy",   {31'd0, busy}, 32'd0);
      check("midreset done",   {31'd0, done}, 32'd0);
      check("midreset result", Result,        32'd0);

      // Back-to-back: second start issued in the DONE cycle
      launch(3'd0, 32'd6, 32'd7);
      wait_done(1, lat, bcnt);
      check("b2b first result", Result, 32'd42);
      launch(3'd1, 32'h8000_0000, 32'h8000_0000);
      wait_done(1, lat, bcnt);
      check("b2b second result",  Result,   32'h4000_0000);
      check("b2b second latency", 32'(lat), 32'd34);

      // Randomized ops, mostly back-to-back, with special-case biasing
      for (int i = 0; i < 60; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 9))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 15));
            3: a = 32'($urandom_range(0, 255));
            default: ;
         endcase
         exp = ref_md(op, a, b);
         launch(op, a, b);
         wait_done(1, lat, bcnt);
         check($sformatf("rnd%0d op%0d result", i, op), Result, exp);
         check($sformatf("rnd%0d op%0d latency", i, op), 32'(lat),
               is_special(op, a, b) ? 32'd1 : 32'd34);
         if ($urandom_range(0, 1) == 0) begin
            @(posedge clk); #1;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
